// File: rtl/instruction_fetch_stage.sv
// Fetch stage with IF/ID output register: PC, single-outstanding imem requests, redirect/flush.
// Optional macro FETCH_BUF_EN replaces the single output register with a 2-entry fetch FIFO.
module instruction_fetch_stage #(
    parameter int                    INSTRSIZE = 32,
    parameter int                    ADDRSIZE  = 64,
    parameter logic [ADDRSIZE-1:0]   RESET_PC  = {ADDRSIZE{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDRSIZE-1:0]   imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [INSTRSIZE-1:0]  imem_rdata,
    input  logic                  redirect_valid,
    input  logic [ADDRSIZE-1:0]   redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [INSTRSIZE-1:0]  id_instruction,
    output logic [ADDRSIZE-1:0]   id_pc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    localparam logic [ADDRSIZE-1:0] PC_STEP = ADDRSIZE'(32'd4);

    state_t                state_r;
    state_t                state_s;
    logic [ADDRSIZE-1:0]   pc_r;
    logic [ADDRSIZE-1:0]   pc_s;
    logic [ADDRSIZE-1:0]   req_pc_r;
    logic [ADDRSIZE-1:0]   req_pc_s;
    logic [ADDRSIZE-1:0]   redirect_target_s;
    logic                  imem_req_s;
    logic                  accept_s;
    logic                  resp_s;

    assign redirect_target_s = {redirect_pc[ADDRSIZE-1:2], 2'b00};
    assign accept_s          = imem_req_s && imem_ready;
    assign resp_s            = imem_rvalid && (state_r == ST_WAIT);
    assign imem_req          = imem_req_s;
    assign imem_addr         = pc_r;

    // Next-state, next-PC and captured request address
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        req_pc_s = req_pc_r;
        if (accept_s) begin
            pc_s     = pc_r + PC_STEP;
            req_pc_s = pc_r;
        end else begin
            pc_s     = pc_r;
            req_pc_s = req_pc_r;
        end
        case (state_r)
            ST_IDLE: state_s = ST_REQ;
            ST_REQ: begin
                if (accept_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                // A request may only be issued from WAIT in the buffered build, as the response lands
                if (imem_rvalid) begin
                    state_s = accept_s ? ST_WAIT : ST_REQ;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        if (redirect_valid) begin
            pc_s = redirect_target_s;
            if (accept_s) begin
                state_s = ST_DROP;
            end else if (((state_r == ST_WAIT) || (state_r == ST_DROP)) && !imem_rvalid) begin
                state_s = ST_DROP;
            end else begin
                state_s = ST_REQ;
            end
        end else begin
            pc_s = pc_s;
        end
    end

    // FSM, PC and request-address registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            req_pc_r <= {ADDRSIZE{1'b0}};
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            req_pc_r <= req_pc_s;
        end
    end

`ifdef FETCH_BUF_EN
    logic [INSTRSIZE-1:0]  buf_instr_r [2];
    logic [ADDRSIZE-1:0]   buf_pc_r    [2];
    logic                  rd_ptr_r;
    logic                  wr_ptr_r;
    logic [1:0]            count_r;
    logic                  pop_s;
    logic                  push_s;
    logic [2:0]            occupancy_s;

    assign pop_s  = (count_r != 2'd0) && id_ready;
    assign push_s = resp_s && !redirect_valid;

    // Entries held or in flight after this cycle's pop; a head popped now frees a slot for a new fetch
    always_comb begin
        occupancy_s = {1'b0, count_r} + {2'b00, (state_r == ST_WAIT)} - {2'b00, pop_s};
        imem_req_s  = ((state_r == ST_REQ) || ((state_r == ST_WAIT) && imem_rvalid))
                      && (occupancy_s < 3'd2);
    end

    // Fetch FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_instr_r[i] <= {INSTRSIZE{1'b0}};
                buf_pc_r[i]    <= {ADDRSIZE{1'b0}};
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                buf_instr_r[wr_ptr_r] <= imem_rdata;
                buf_pc_r[wr_ptr_r]    <= req_pc_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign id_valid       = (count_r != 2'd0);
    assign id_instruction = buf_instr_r[rd_ptr_r];
    assign id_pc          = buf_pc_r[rd_ptr_r];
`else
    logic                  id_valid_r;
    logic [INSTRSIZE-1:0]  id_instruction_r;
    logic [ADDRSIZE-1:0]   id_pc_r;

    // Request only when the IF/ID register is guaranteed empty by the time the response lands
    always_comb begin
        if (state_r == ST_REQ) begin
            imem_req_s = !id_valid_r || id_ready;
        end else begin
            imem_req_s = 1'b0;
        end
    end

    // IF/ID output register
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_r       <= 1'b0;
            id_instruction_r <= {INSTRSIZE{1'b0}};
            id_pc_r          <= {ADDRSIZE{1'b0}};
        end else if (redirect_valid) begin
            id_valid_r <= 1'b0;
        end else if (resp_s) begin
            id_valid_r       <= 1'b1;
            id_instruction_r <= imem_rdata;
            id_pc_r          <= req_pc_r;
        end else if (id_valid_r && id_ready) begin
            id_valid_r <= 1'b0;
        end else begin
            id_valid_r <= id_valid_r;
        end
    end

    assign id_valid       = id_valid_r;
    assign id_instruction = id_instruction_r;
    assign id_pc          = id_pc_r;
`endif

endmodule
